reciprocal_gen: RTL and testbench

RECIPROCAL_GEN -- requirements
Module: reciprocal_gen

---
 rtl/reciprocal_gen.sv | 103 ++++++++++
 tb/tb_reciprocal_gen.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/reciprocal_gen.sv
// Serial restoring divider: recip_o = floor(65536/N), 17 cycles start-to-done, one request per 19 cycles; start_i is ignored while busy.
// Define RECIP_ROUND_EN for round-to-nearest: 18 iterations plus a guard bit, saturating at 17'h1FFFF.
module reciprocal_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [15:0] n_i,
  output logic [16:0] recip_o,
  output logic        done_o,
  output logic        busy_o,
  output logic        dz_o
);

`ifdef RECIP_ROUND_EN
  localparam int QW = 18;
`else
  localparam int QW = 17;
`endif
  localparam logic [4:0] ITERS = 5'(QW);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [15:0]   nReg;
  logic [16:0]   rem;
  logic [QW-2:0] quo;
  logic [4:0]    iterCnt;

  logic          divBit;
  logic [16:0]   shifted;
  logic [16:0]   diff;
  logic          fits;
  logic [QW-1:0] quoNext;
  logic [16:0]   result;
`ifdef RECIP_ROUND_EN
  logic [17:0]   rounded;
`endif

  // The dividend is a single 1 followed by zeros, so only the first iteration shifts in a 1.
  always_comb begin
    divBit  = (iterCnt == ITERS);
    shifted = {rem[15:0], divBit};
    fits    = rem[16] | (shifted >= {1'b0, nReg});
    diff    = shifted - {1'b0, nReg};
    quoNext = {quo, fits};
`ifdef RECIP_ROUND_EN
    rounded = {1'b0, quoNext[17:1]} + 18'(quoNext[0]);
    result  = rounded[17] ? 17'h1FFFF : rounded[16:0];
`else
    result  = quoNext;
`endif
  end

  assign busy_o = (state == CALC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      nReg    <= '0;
      rem     <= '0;
      quo     <= '0;
      iterCnt <= '0;
      recip_o <= '0;
      done_o  <= 1'b0;
      dz_o    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            nReg    <= n_i;
            rem     <= '0;
            quo     <= '0;
            iterCnt <= ITERS;
            dz_o    <= (n_i == 16'd0);
            if (n_i == 16'd0) begin
              recip_o <= 17'h1FFFF;
              done_o  <= 1'b1;
              state   <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem     <= fits ? diff : shifted;
          quo     <= quoNext[QW-2:0];
          iterCnt <= iterCnt - 5'd1;
          if (iterCnt == 5'd1) begin
            recip_o <= result;
            done_o  <= 1'b1;
            state   <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reciprocal_gen.sv
// Directed bench for reciprocal_gen: latency, results, divide-by-zero, ignored inputs, reset abort, back-to-back starts.
module tb_reciprocal_gen;

`ifdef RECIP_ROUND_EN
  localparam int LAT = 18;
  localparam logic [16:0] R6 = 17'd10923;
`else
  localparam int LAT = 17;
  localparam logic [16:0] R6 = 17'd10922;
`endif

  logic        clk;
  logic        rstN;
  logic        startI;
  logic [15:0] nI;
  logic [16:0] recipO;
  logic        doneO;
  logic        busyO;
  logic        dzO;

  int checks = 0;
  int errors = 0;

  reciprocal_gen dut (
    .clk     (clk),
    .rst_n   (rstN),
    .start_i (startI),
    .n_i     (nI),
    .recip_o (recipO),
    .done_o  (doneO),
    .busy_o  (busyO),
    .dz_o    (dzO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish within 100000 ns");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one request, then measure edges from the start edge to done_o and count busy cycles.
  task automatic doReq(input logic [15:0] n, output int lat, output int busyN,
                       output int extraDone, output logic [16:0] r, output logic dz);
    startI = 1'b1;
    nI     = n;
    tick();
    startI = 1'b0;
    nI     = ~n;
    lat    = -1;
    busyN  = 0;
    for (int k = 0; k < 40; k++) begin
      if (doneO) begin
        lat = k;
        break;
      end
      if (busyO) busyN++;
      tick();
    end
    r  = recipO;
    dz = dzO;
    extraDone = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (doneO) extraDone++;
    end
  endtask

  int          lat;
  int          busyN;
  int          extraDone;
  logic [16:0] r;
  logic        dz;
  int          cnt;
  int          busySeen;
  logic [16:0] rCap;
  int          pc;
  int          pt[8];
  logic [16:0] pr[8];

  initial begin
    rstN   = 1'b0;
    startI = 1'b0;
    nI     = 16'd0;
    repeat (3) tick();
    check("reset_recip", 32'(recipO), 32'd0);
    check("reset_done",  32'(doneO),  32'd0);
    check("reset_busy",  32'(busyO),  32'd0);
    check("reset_dz",    32'(dzO),    32'd0);
    #2 rstN = 1'b1;
    tick();
    tick();

    doReq(16'd3, lat, busyN, extraDone, r, dz);
    check("n3_latency", 32'(lat),       32'(LAT));
    check("n3_recip",   32'(r),         32'd21845);
    check("n3_dz",      32'(dz),        32'd0);
    check("n3_busy",    32'(busyN),     32'(LAT));
    check("n3_single",  32'(extraDone), 32'd0);

    doReq(16'd0, lat, busyN, extraDone, r, dz);
    check("n0_latency", 32'(lat),   32'd0);
    check("n0_recip",   32'(r),     32'h1FFFF);
    check("n0_dz",      32'(dz),    32'd1);
    check("n0_busy",    32'(busyN), 32'd0);
    check("n0_dz_held", 32'(dzO),   32'd1);

    doReq(16'd1, lat, busyN, extraDone, r, dz);
    check("n1_recip",   32'(r),   32'h10000);
    check("n1_dz",      32'(dz),  32'd0);
    check("n1_latency", 32'(lat), 32'(LAT));

    doReq(16'd6, lat, busyN, extraDone, r, dz);
    check("n6_recip",   32'(r),   32'(R6));
    check("n6_latency", 32'(lat), 32'(LAT));

    doReq(16'd65535, lat, busyN, extraDone, r, dz);
    check("n65535_recip", 32'(r), 32'd1);

    doReq(16'd2, lat, busyN, extraDone, r, dz);
    check("n2_recip", 32'(r), 32'h08000);

    // N=7 while n_i changes and start_i pulses mid-computation
    startI = 1'b1;
    nI     = 16'd7;
    tick();
    startI = 1'b0;
    tick();
    tick();
    nI     = 16'd2;
    startI = 1'b1;
    tick();
    startI = 1'b0;
    cnt    = 0;
    rCap   = '0;
    for (int k = 0; k < 45; k++) begin
      tick();
      if (doneO) begin
        cnt++;
        rCap = recipO;
      end
    end
    check("n7_done_count", 32'(cnt),  32'd1);
    check("n7_recip",      32'(rCap), 32'd9362);
    check("n7_idle_after", 32'(busyO), 32'd0);

    // Reset asserted during iteration 9 of N=5
    startI = 1'b1;
    nI     = 16'd5;
    tick();
    startI = 1'b0;
    repeat (8) tick();
    check("n5_busy_before_rst", 32'(busyO), 32'd1);
    #2 rstN = 1'b0;
    #1;
    check("rst_mid_recip", 32'(recipO), 32'd0);
    check("rst_mid_done",  32'(doneO),  32'd0);
    check("rst_mid_busy",  32'(busyO),  32'd0);
    check("rst_mid_dz",    32'(dzO),    32'd0);
    tick();
    rstN     = 1'b1;
    cnt      = 0;
    busySeen = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (doneO) cnt++;
      if (busyO) busySeen++;
    end
    check("rst_no_done",   32'(cnt),      32'd0);
    check("rst_no_busy",   32'(busySeen), 32'd0);
    check("rst_recip_low", 32'(recipO),   32'd0);

    doReq(16'd5, lat, busyN, extraDone, r, dz);
    check("n5_recip",   32'(r),   32'd13107);
    check("n5_latency", 32'(lat), 32'(LAT));

    // start_i held high with N=4 for 60 cycles
    startI = 1'b1;
    nI     = 16'd4;
    pc     = 0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (doneO) begin
        if (pc < 8) begin
          pt[pc] = k;
          pr[pc] = recipO;
        end
        pc++;
      end
    end
    startI = 1'b0;
    check("held_pulse_count", 32'(pc), 32'd3);
    for (int i = 0; i < pc && i < 8; i++) begin
      check("held_recip", 32'(pr[i]), 32'd16384);
    end
    for (int i = 1; i < pc && i < 8; i++) begin
      check("held_spacing", 32'(pt[i] - pt[i-1]), 32'(LAT + 2));
    end
    if (pc > 0) check("held_first_latency", 32'(pt[0] - 1), 32'(LAT));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
